// File: rtl/aes_sbox_stream_ctrl_pkg.sv
// Constants and sizing helpers shared by the masked AES S-box wrapper and its
// stream controller.
package aes_sbox_stream_ctrl_pkg;

    localparam int SBOX_LATENCY_DEFAULT = 4;
    localparam int SHARES_DEFAULT       = 2;

    // Bits needed to hold any count from 0 up to max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/aes_sbox_stream_ctrl_fifo.sv
// Share-preserving circular FIFO: each entry holds all shares of one byte,
// and they are stored and returned untouched.
module shared_byte_fifo
    import aes_sbox_stream_ctrl_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int DEPTH  = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_en_i,
    input  logic [8*SHARES-1:0]           wr_data_i,
    input  logic                          rd_en_i,
    output logic [8*SHARES-1:0]           rd_data_o,
    output logic [cnt_width(DEPTH)-1:0]   occ_o
);

    localparam int W     = 8 * SHARES;
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (wr_en_i) begin
            mem_d[wptr_q] = wr_data_i;
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (rd_en_i) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({wr_en_i, rd_en_i})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign occ_o     = occ_q;

    a_no_write_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_en_i && (occ_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/aes_sbox_stream_ctrl.sv
// Feeds a masked pipelined AES S-box one shared byte per cycle and buffers its
// results; credits cover in-flight bytes so no result is ever dropped.
module aes_sbox_stream_ctrl
    import aes_sbox_stream_ctrl_pkg::*;
#(
    parameter int SHARES       = SHARES_DEFAULT,
    parameter int SBOX_LATENCY = SBOX_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH   = 6
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  InValidxSI,
    output logic                  InReadyxSO,
    input  logic [8*SHARES-1:0]   _InDataxDI,
    output logic [8*SHARES-1:0]   _SboxInxDO,
    input  logic [8*SHARES-1:0]   _SboxOutxDI,
    output logic                  OutValidxSO,
    input  logic                  OutReadyxSI,
    output logic [8*SHARES-1:0]   _OutDataxDO,
    output logic                  BusyxSO
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [SBOX_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]        occ, occ_d;
    logic                    in_ready_q, in_ready_d;
    logic                    accept, capture, dequeue;

    assign accept  = InValidxSI & in_ready_q;
    assign capture = vld_pipe_q[SBOX_LATENCY-1];
    assign dequeue = OutValidxSO & OutReadyxSI;

    // Ready is registered from next-cycle credits, which equals the credit
    // check on current state while keeping it low throughout reset.
    always_comb begin
        vld_pipe_d = SBOX_LATENCY'({vld_pipe_q, accept});
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(capture);
        occ_d      = occ;
        if (capture && !dequeue) begin
            occ_d = occ + CNT_W'(1);
        end else if (!capture && dequeue) begin
            occ_d = occ - CNT_W'(1);
        end
        in_ready_d = (SUM_W'(occ_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH);
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            vld_pipe_q <= '0;
            inflight_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            inflight_q <= inflight_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Zero the S-box input on idle cycles so stale shares are never re-presented.
    assign _SboxInxDO = accept ? _InDataxDI : '0;

    shared_byte_fifo #(
        .SHARES (SHARES),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (ClkxCI),
        .rst_ni    (RstxBI),
        .wr_en_i   (capture),
        .wr_data_i (_SboxOutxDI),
        .rd_en_i   (dequeue),
        .rd_data_o (_OutDataxDO),
        .occ_o     (occ)
    );

    assign InReadyxSO  = in_ready_q;
    assign OutValidxSO = (occ != '0);
    assign BusyxSO     = (inflight_q != '0) | (occ != '0);

endmodule
